// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser.
// Optional coin10 inventory is enabled with CHANGE_DISPENSER_INV_EN.
package change_dispenser_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP,
      DONE
   } cd_state_t;

   // Coin values expressed in nickels
   localparam int unsigned NICKEL_5  = 1;
   localparam int unsigned NICKEL_10 = 2;

   // Counter width able to hold the larger of the two (cycles - 1) load values
   function automatic int unsigned cd_cnt_w(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/cd_pulse_timer.sv
// Loadable down-counter timing both the coin pulse and the gap after it.
// expire is high on the last cycle of the loaded interval.
module cd_pulse_timer #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load wins; otherwise count down and rest at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change-return transmitter: converts a refund in nickels into timed
// coin10/coin5 pulses, largest coin first, then a one-cycle done.
// Define CHANGE_DISPENSER_INV_EN to add a finite coin10 stock with refill/low10.
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int unsigned AMT_W      = 6,
   parameter int unsigned PULSE_CYC  = 2,
   parameter int unsigned GAP_CYC    = 2
`ifdef CHANGE_DISPENSER_INV_EN
   ,
   parameter int unsigned INV10_INIT = 8
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [AMT_W-1:0] amount,
`ifdef CHANGE_DISPENSER_INV_EN
   input  logic             refill,
   output logic             low10,
`endif
   output logic             busy,
   output logic             done,
   output logic             coin10,
   output logic             coin5
);

   localparam int unsigned      CNT_W    = cd_cnt_w(PULSE_CYC, GAP_CYC);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
   localparam logic [AMT_W-1:0] AMT_5    = AMT_W'(NICKEL_5);
   localparam logic [AMT_W-1:0] AMT_10   = AMT_W'(NICKEL_10);

   cd_state_t        state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             coin10_q, coin10_d;
   logic             coin5_q, coin5_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_expire;
   logic             start_coin;
   logic             stock_ok;
   logic [AMT_W-1:0] cur_amt;

   cd_pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_expire)
   );

   // The first coin is chosen from the incoming amount, later ones from rem
   assign cur_amt = (state_q == IDLE) ? amount : rem_q;

   // Next-state and next-output logic; coin choice shared by IDLE and GAP
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      coin10_d   = coin10_q;
      coin5_d    = coin5_q;
      tmr_load   = 1'b0;
      tmr_val    = PULSE_LD;
      start_coin = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d   = 1'b0;
            coin10_d = 1'b0;
            coin5_d  = 1'b0;
            if (req) begin
               busy_d = 1'b1;
               rem_d  = amount;
               if (amount == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  start_coin = 1'b1;
               end
            end
         end
         PULSE: begin
            if (tmr_expire) begin
               state_d  = GAP;
               coin10_d = 1'b0;
               coin5_d  = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
            end
         end
         GAP: begin
            if (tmr_expire) begin
               if (rem_q != '0) begin
                  start_coin = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      if (start_coin) begin
         state_d  = PULSE;
         tmr_load = 1'b1;
         tmr_val  = PULSE_LD;
         if (cur_amt >= AMT_10 && stock_ok) begin
            coin10_d = 1'b1;
            rem_d    = cur_amt - AMT_10;
         end else begin
            coin5_d  = 1'b1;
            rem_d    = cur_amt - AMT_5;
         end
      end
   end

   // FSM state and registered outputs; reset abandons any refund in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         coin10_q <= 1'b0;
         coin5_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         coin10_q <= coin10_d;
         coin5_q  <= coin5_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign coin10 = coin10_q;
   assign coin5  = coin5_q;

`ifdef CHANGE_DISPENSER_INV_EN
   localparam int unsigned INV_W = (INV10_INIT < 2) ? 1 : $clog2(INV10_INIT + 1);

   logic [INV_W-1:0] stock_q, stock_d;
   logic             low10_q;

   assign stock_ok = (stock_q != '0);

   // Stock tracks coin10 pulse starts; a refill overrides a same-cycle take
   always_comb begin
      stock_d = stock_q;
      if (refill)
         stock_d = INV_W'(INV10_INIT);
      else if (start_coin && coin10_d)
         stock_d = stock_q - INV_W'(1);
   end

   // Stock register and its registered empty flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         stock_q <= INV_W'(INV10_INIT);
         low10_q <= 1'b0;
      end else begin
         stock_q <= stock_d;
         low10_q <= (stock_d == '0);
      end
   end

   assign low10 = low10_q;
`else
   assign stock_ok = 1'b1;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected coin/done
// events (kind + cycle), a monitor pops and compares on each DUT event.
module tb_change_dispenser;

   localparam int AMT_W = 6;
   localparam int PC    = 2;
   localparam int GC    = 2;
   localparam int PER   = PC + GC;
   localparam int INV   = 1;
`ifdef CHANGE_DISPENSER_INV_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             req = 1'b0;
   logic [AMT_W-1:0] amount = '0;
   logic             busy, done, coin10, coin5;
`ifdef CHANGE_DISPENSER_INV_EN
   logic             refill = 1'b0;
   logic             low10;
`endif

   always #5 clk = ~clk;

   change_dispenser #(
      .AMT_W      (AMT_W),
      .PULSE_CYC  (PC),
      .GAP_CYC    (GC)
`ifdef CHANGE_DISPENSER_INV_EN
      ,
      .INV10_INIT (INV)
`endif
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .amount (amount),
`ifdef CHANGE_DISPENSER_INV_EN
      .refill (refill),
      .low10  (low10),
`endif
      .busy   (busy),
      .done   (done),
      .coin10 (coin10),
      .coin5  (coin5)
   );

   typedef enum int {EV_C10 = 0, EV_C5 = 1, EV_DONE = 2} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       cyc;
   } ev_t;

   ev_t exp_q[$];
   int  errs = 0;
   int  checks = 0;
   int  edge_n = 0;
   int  busy_lo = 1;
   int  busy_hi = 0;
   int  mstock = INV;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, edge_n);
      end
   endtask

   // Reference model: greedy coin list from plain arithmetic, events at fixed period
   task automatic issue(input int n);
      int m, r, k;
      @(negedge clk);
      req    = 1'b1;
      amount = AMT_W'(n);
      m = edge_n + 1;
      r = n;
      k = 0;
      while (r > 0) begin
         if (r >= 2 && (!INV_EN || mstock > 0)) begin
            exp_q.push_back('{EV_C10, m + k * PER});
            r -= 2;
            if (INV_EN) mstock--;
         end else begin
            exp_q.push_back('{EV_C5, m + k * PER});
            r -= 1;
         end
         k++;
      end
      exp_q.push_back('{EV_DONE, m + k * PER});
      busy_lo = m;
      busy_hi = m + k * PER;
      @(posedge clk);
      #1;
      req    = 1'b0;
      amount = AMT_W'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         chk("refund_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

`ifdef CHANGE_DISPENSER_INV_EN
   task automatic do_refill();
      @(negedge clk);
      refill = 1'b1;
      @(posedge clk);
      #1;
      refill = 1'b0;
      mstock = INV;
      @(negedge clk);
      chk("low10_after_refill", low10, 0);
   endtask
`endif

   task automatic outputs_zero(input string name);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_done"}, done, 0);
      chk({name, "_coin10"}, coin10, 0);
      chk({name, "_coin5"}, coin5, 0);
   endtask

   // Monitor: pop expected events on rising outputs, plus per-cycle invariants
   logic p10 = 1'b0, p5 = 1'b0, pd = 1'b0;
   int   w10 = 0, w5 = 0;

   task automatic pop_chk(input ev_kind_t k);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_event", int'(k), -1);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", int'(k), int'(e.kind));
         chk("event_cycle", edge_n, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (coin10 && !p10) pop_chk(EV_C10);
      if (coin5 && !p5) pop_chk(EV_C5);
      if (done && !pd) pop_chk(EV_DONE);
      if (done && pd) chk("done_one_cycle", 2, 1);
      if (coin10) w10++;
      else if (p10) begin
         chk("coin10_width", w10, PC);
         w10 = 0;
      end
      if (coin5) w5++;
      else if (p5) begin
         chk("coin5_width", w5, PC);
         w5 = 0;
      end
      chk("coin_mutex", int'(coin10 & coin5), 0);
      chk("busy", busy, int'(edge_n >= busy_lo && edge_n <= busy_hi));
      p10 = coin10;
      p5  = coin5;
      pd  = done;
   end

   initial begin
      int lim;
      repeat (3) @(posedge clk);
      @(negedge clk);
      outputs_zero("reset_state");
`ifdef CHANGE_DISPENSER_INV_EN
      chk("reset_low10", low10, 0);
`endif
      reset = 1'b1;
      mstock = INV;

      // Directed: mixed coins, zero amount, max amount
      issue(3);  wait_idle();
      issue(0);  wait_idle();
      issue(63); wait_idle();

      // Second req while busy must be ignored
      issue(4);
      repeat (2) @(negedge clk);
      req = 1'b1;
      amount = AMT_W'(7);
      @(posedge clk);
      #1;
      req = 1'b0;
      wait_idle();

      // Reset in cycle 3 of a 5-nickel refund abandons it
      issue(5);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      lim = edge_n + 1;
      for (int i = exp_q.size() - 1; i >= 0; i--)
         if (exp_q[i].cyc >= lim) exp_q.delete(i);
      busy_hi = lim - 1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      mstock = INV;
      repeat (3) begin
         @(negedge clk);
         outputs_zero("after_abort");
      end
      chk("abort_queue_empty", exp_q.size(), 0);
      issue(5); wait_idle();

`ifdef CHANGE_DISPENSER_INV_EN
      // Stock of one: first coin10 then coin5s, low10 set after first pulse
      do_refill();
      issue(4);
      @(negedge clk);
      chk("low10_after_first", low10, 1);
      wait_idle();
      do_refill();
`endif

      // Randomized refunds
      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
`ifdef CHANGE_DISPENSER_INV_EN
         if ($urandom_range(0, 3) == 0) do_refill();
`endif
         issue(int'($urandom_range(0, 63)));
         wait_idle();
`ifdef CHANGE_DISPENSER_INV_EN
         @(negedge clk);
         chk("low10_track", low10, int'(mstock == 0));
`endif
      end

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
